chunked_add_sub_sequencer: RTL and testbench



---
 rtl/chunked_add_sub_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_chunked_add_sub_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/chunked_add_sub_sequencer.sv
// Wide add/subtract performed one CHUNK-bit slice per cycle through a
// ripple-carry adder, with registered carry, overflow and zero flags.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  logic p;
  logic g;
  logic t;
  xor u_x0 (p, a, b);
  xor u_x1 (sum, p, carry_in);
  and u_a0 (g, a, b);
  and u_a1 (t, p, carry_in);
  or  u_o0 (carry_out, g, t);
endmodule

module ripple_carry_adder #(
  parameter int    N     = 16,
  parameter string MODEL = "Structural"
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] sum,
  output logic         carry_out
);
  if (MODEL == "Behavioral") begin : g_beh
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b}
                            + {{N{1'b0}}, carry_in};
  end else if (MODEL == "DataFlow" || MODEL == "Structural") begin : g_chain
    logic [N:0] c;
    assign c[0]      = carry_in;
    assign carry_out = c[N];
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (MODEL == "DataFlow") begin : g_df
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end else begin : g_st
        full_adder u_fa (
          .a         (a[i]),
          .b         (b[i]),
          .carry_in  (c[i]),
          .sum       (sum[i]),
          .carry_out (c[i+1])
        );
      end
    end
  end else begin : g_bad
    $error("ripple_carry_adder: unknown MODEL");
  end
endmodule

module chunked_add_sub_sequencer #(
  parameter int    W     = 64,
  parameter int    CHUNK = 16,
  parameter string MODEL = "Structural"
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  input  logic         in_carry,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_carry,
  output logic         out_overflow,
  output logic         out_zero
);
  localparam int NUM_CHUNKS = W / CHUNK;
  localparam int IDX_W =
    (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_CHUNKS - 1);

  if ((CHUNK < 2) || (W % CHUNK != 0)) begin : g_chk
    $error("W must be a multiple of CHUNK, CHUNK >= 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_d;
  logic [IDX_W-1:0] idx;
  logic             carry_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     sum_q;
  logic [W-1:0]     sum_d;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] add_sum;
  logic             add_co;
  logic             accept;
  logic             last;

  assign a_sl = a_q[int'(idx)*CHUNK +: CHUNK];
  assign b_sl = b_q[int'(idx)*CHUNK +: CHUNK];

  ripple_carry_adder #(
    .N     (CHUNK),
    .MODEL (MODEL)
  ) u_rca (
    .a         (a_sl),
    .b         (b_sl),
    .carry_in  (carry_q),
    .sum       (add_sum),
    .carry_out (add_co)
  );

  always_comb begin
    sum_d = sum_q;
    sum_d[int'(idx)*CHUNK +: CHUNK] = add_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        last = (idx == LAST_IDX);
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Flags are judged on the full word once the top slice lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      carry_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      out_carry    <= 1'b0;
      out_overflow <= 1'b0;
      out_zero     <= 1'b0;
    end else if (accept) begin
      a_q     <= in_a;
      b_q     <= in_sub ? ~in_b : in_b;
      carry_q <= in_sub ? 1'b1 : in_carry;
      idx     <= '0;
    end else if (state == RUN) begin
      sum_q   <= sum_d;
      carry_q <= add_co;
      idx     <= idx + 1'b1;
      if (last) begin
        out_carry    <= add_co;
        out_overflow <= (a_q[W-1] == b_q[W-1])
                      & (sum_d[W-1] != a_q[W-1]);
        out_zero     <= (sum_d == '0);
      end
    end
  end

  assign out_sum = sum_q;

endmodule

// File: tb/tb_chunked_add_sub_sequencer.sv
// Directed bench for chunked_add_sub_sequencer at W=64, CHUNK=16.

module tb_chunked_add_sub_sequencer;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         in_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         out_overflow;
  logic         out_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chunked_add_sub_sequencer #(
    .W     (64),
    .CHUNK (16),
    .MODEL ("Structural")
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_sub       (in_sub),
    .in_carry     (in_carry),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .out_zero     (out_zero)
  );

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, W'(n), W'(4));
  endtask

  task automatic run_op(input string tag,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic sub,
                        input logic cin,
                        input logic [W-1:0] e_sum,
                        input logic e_c,
                        input logic e_v,
                        input logic e_z);
    int n;
    chk({tag, "_rdy"}, W'(in_ready), W'(1));
    in_a = a; in_b = b; in_sub = sub; in_carry = cin;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_busy"}, W'(in_ready), W'(0));
    wait_valid(tag, n);
    chk({tag, "_sum"}, out_sum, e_sum);
    chk({tag, "_c"}, W'(out_carry), W'(e_c));
    chk({tag, "_v"}, W'(out_overflow), W'(e_v));
    chk({tag, "_z"}, W'(out_zero), W'(e_z));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drop"}, W'(out_valid), W'(0));
    chk({tag, "_idle"}, W'(in_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] snap;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_carry = 1'b0;
    #12;
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_sum", out_sum, '0);
    chk("rst_flags", W'({out_carry, out_overflow, out_zero}), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_ready", W'(in_ready), W'(1));

    run_op("add32", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
    run_op("sub_eq", 64'h5, 64'h5, 1'b1, 1'b0,
           64'h0, 1'b1, 1'b0, 1'b1);
    run_op("sub_brw", 64'h0, 64'h1, 1'b1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_op("chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op("sub_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           1'b1, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1);

    // Backpressure with new operands pending.
    in_a = 64'h1234_0000_0000_0001; in_b = 64'h0000_0000_0000_0002;
    in_sub = 1'b0; in_carry = 1'b0; in_valid = 1'b1;
    step();
    in_a = 64'h10; in_b = 64'h20;
    wait_valid("bp", n);
    snap = out_sum;
    chk("bp_sum", snap, 64'h1234_0000_0000_0003);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold", out_sum, snap);
      chk("bp_vld", W'(out_valid), W'(1));
      chk("bp_rdy", W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_drop", W'(out_valid), W'(0));
    chk("bp_idle", W'(in_ready), W'(1));
    step();
    in_valid = 1'b0;
    chk("bp_acc", W'(in_ready), W'(0));
    wait_valid("bp2", n);
    chk("bp2_sum", out_sum, 64'h30);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Abort by reset in the middle of RUN.
    in_a = 64'h1111_1111_1111_1111; in_b = 64'h1111_1111_1111_1111;
    in_sub = 1'b0; in_carry = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ab_valid", W'(out_valid), W'(0));
    chk("ab_sum", out_sum, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ab_ready", W'(in_ready), W'(1));
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ab_stale", W'(out_valid), W'(0));
    end
    run_op("fresh", 64'h1, 64'h1, 1'b0, 1'b0,
           64'h2, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
